gauss_filter_sched: RTL and testbench

Frame-granular round-robin scheduler that shares one GaussFilter instance between two pixel-stream requesters. It grants the filter to one requester per frame and steers that requester's 24-bit RGB stream into the filter. Filter results are routed back to the owner. The grant is released only after every output pixel of the frame has returned, so frames never interleave inside the filter.

---
 rtl/gauss_sched_pkg.sv | 11 +
 rtl/gauss_sched_rr.sv | 24 ++
 rtl/gauss_filter_sched.sv | 137 +++++++++++++
 tb/tb_gauss_filter_sched.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gauss_sched_pkg.sv
// rtl/gauss_sched_pkg.sv - shared types and constants for the GaussFilter frame scheduler
package gauss_sched_pkg;
  localparam int RGB_W = 24;
  localparam int LEN_W = 17;
  localparam int NREQ  = 2;

  typedef logic [RGB_W-1:0] rgb_t;
  typedef logic [LEN_W-1:0] len_t;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_e;
endpackage

// File: rtl/gauss_sched_rr.sv
// rtl/gauss_sched_rr.sv - 2-way round-robin picker; the requester after the last grant wins ties
module gauss_sched_rr
  import gauss_sched_pkg::*;
(
  input  logic [NREQ-1:0] i_req,
  input  logic            i_last,
  output logic [NREQ-1:0] o_pick,
  output logic            o_any
);

  always_comb begin
    o_pick = '0;
    if (i_last) begin
      if (i_req[0])      o_pick = 2'b01;
      else if (i_req[1]) o_pick = 2'b10;
    end else begin
      if (i_req[1])      o_pick = 2'b10;
      else if (i_req[0]) o_pick = 2'b01;
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/gauss_filter_sched.sv
// rtl/gauss_filter_sched.sv - frame-granular round-robin share of one GaussFilter between two pixel streams
module gauss_filter_sched #(
  parameter int LEN_W = 17,
  parameter int RGB_W = 24
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [1:0]         i_req,
  input  logic [2*LEN_W-1:0] i_len,
  output logic [1:0]         o_gnt,
  output logic [1:0]         o_done,
  input  logic [1:0]         i_src_vld,
  input  logic [2*RGB_W-1:0] i_src_data,
  output logic [1:0]         o_src_busy,
  output logic [1:0]         o_dst_vld,
  output logic [RGB_W-1:0]   o_dst_data,
  input  logic [1:0]         i_dst_busy,
  output logic               o_flt_vld,
  output logic [RGB_W-1:0]   o_flt_data,
  input  logic               i_flt_busy,
  input  logic               i_flt_vld,
  input  logic [RGB_W-1:0]   i_flt_data,
  output logic               o_flt_busy,
  output logic               o_overrun
);
  import gauss_sched_pkg::*;

  state_e           state_q;
  logic [1:0]       gnt_q;
  logic [1:0]       done_q;
  logic             own_q;
  logic             last_q;
  logic             overrun_q;
  logic [LEN_W-1:0] in_rem_q;
  logic [LEN_W-1:0] out_rem_q;
  logic [LEN_W-1:0] in_rem_d;
  logic [LEN_W-1:0] out_rem_d;

  logic [1:0]       pick;
  logic             any_req;
  logic [LEN_W-1:0] len_pick;
  logic             in_open;
  logic             routing;
  logic             in_acc;
  logic             out_acc;
  logic             stray;

  gauss_sched_rr u_rr (
    .i_req  (i_req),
    .i_last (last_q),
    .o_pick (pick),
    .o_any  (any_req)
  );

  assign len_pick = pick[1] ? i_len[2*LEN_W-1:LEN_W] : i_len[LEN_W-1:0];

  // Input side closes as soon as in_rem hits zero; output side stays open while results are owed.
  assign in_open = (state_q == STREAM) && (in_rem_q != '0);
  assign routing = ((state_q == STREAM) || (state_q == DRAIN)) && (out_rem_q != '0);

  always_comb begin
    o_src_busy = 2'b11;
    o_dst_vld  = 2'b00;
    o_flt_vld  = in_open & i_src_vld[own_q];
    o_flt_data = own_q ? i_src_data[2*RGB_W-1:RGB_W] : i_src_data[RGB_W-1:0];
    o_flt_busy = routing & i_dst_busy[own_q];
    o_dst_data = i_flt_data;
    if (in_open) o_src_busy[own_q] = i_flt_busy;
    if (routing) o_dst_vld[own_q]  = i_flt_vld;
  end

  assign in_acc    = o_flt_vld & ~i_flt_busy;
  assign out_acc   = routing & i_flt_vld & ~i_dst_busy[own_q];
  assign stray     = i_flt_vld & ~routing;
  assign in_rem_d  = in_acc  ? in_rem_q  - LEN_W'(1) : in_rem_q;
  assign out_rem_d = out_acc ? out_rem_q - LEN_W'(1) : out_rem_q;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      done_q    <= '0;
      own_q     <= 1'b0;
      last_q    <= 1'b1;
      overrun_q <= 1'b0;
      in_rem_q  <= '0;
      out_rem_q <= '0;
    end else begin
      done_q    <= '0;
      in_rem_q  <= in_rem_d;
      out_rem_q <= out_rem_d;
      if (stray) overrun_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            own_q     <= pick[1];
            in_rem_q  <= len_pick;
            out_rem_q <= len_pick;
            if (len_pick != '0) begin
              state_q <= STREAM;
              gnt_q   <= pick;
            end else begin
              state_q <= DONE;
            end
          end
        end
        STREAM: begin
          if (in_rem_d == '0) begin
            if (out_rem_d == '0) begin
              state_q <= DONE;
              gnt_q   <= '0;
            end else begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (out_rem_d == '0) begin
            state_q <= DONE;
            gnt_q   <= '0;
          end
        end
        DONE: begin
          done_q  <= own_q ? 2'b10 : 2'b01;
          last_q  <= own_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_gnt     = gnt_q;
  assign o_done    = done_q;
  assign o_overrun = overrun_q;

endmodule

// File: tb/tb_gauss_filter_sched.sv
// tb/tb_gauss_filter_sched.sv - self-checking bench with requester, filter and sink models
module tb_gauss_filter_sched;
  import gauss_sched_pkg::*;

  logic               clk;
  logic               i_rst;
  logic [1:0]         i_req;
  logic [2*LEN_W-1:0] i_len;
  logic [1:0]         o_gnt, o_done;
  logic [1:0]         i_src_vld;
  logic [2*RGB_W-1:0] i_src_data;
  logic [1:0]         o_src_busy, o_dst_vld;
  rgb_t               o_dst_data;
  logic [1:0]         i_dst_busy;
  logic               o_flt_vld;
  rgb_t               o_flt_data;
  logic               i_flt_busy, i_flt_vld;
  rgb_t               i_flt_data;
  logic               o_flt_busy, o_overrun;

  int         n_cmp, n_err;
  bit         rnd, stray, flt_real;
  logic [1:0] dst_force;
  int         cyc, rr_last;
  int         done_cnt[2], src_cnt[2], dst_cnt[2];
  int         gnt_log[$];
  logic [1:0] prev_gnt;
  rgb_t       src_q[2][$];
  rgb_t       exp_q[2][$];
  rgb_t       flt_d[$];
  int         flt_ts[$];

  gauss_filter_sched #(.LEN_W(LEN_W), .RGB_W(RGB_W)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_req(i_req), .i_len(i_len),
    .o_gnt(o_gnt), .o_done(o_done),
    .i_src_vld(i_src_vld), .i_src_data(i_src_data), .o_src_busy(o_src_busy),
    .o_dst_vld(o_dst_vld), .o_dst_data(o_dst_data), .i_dst_busy(i_dst_busy),
    .o_flt_vld(o_flt_vld), .o_flt_data(o_flt_data), .i_flt_busy(i_flt_busy),
    .i_flt_vld(i_flt_vld), .i_flt_data(i_flt_data), .o_flt_busy(o_flt_busy),
    .o_overrun(o_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment: requesters, 3-cycle echo filter and sinks. Drives at negedge+1, samples at negedge+4.
  initial begin : monitor
    i_src_vld = '0; i_src_data = '0; i_dst_busy = '0;
    i_flt_busy = 1'b0; i_flt_vld = 1'b0; i_flt_data = '0; flt_real = 1'b0;
    cyc = 0; rr_last = 1; prev_gnt = '0;
    for (int k = 0; k < 2; k++) begin done_cnt[k] = 0; src_cnt[k] = 0; dst_cnt[k] = 0; end
    forever begin
      @(negedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        i_src_vld[k] = (src_q[k].size() > 0) && (!rnd || $urandom_range(3) != 0);
        i_src_data[k*RGB_W +: RGB_W] = (src_q[k].size() > 0) ? src_q[k][0] : '0;
        i_dst_busy[k] = dst_force[k] | (rnd && $urandom_range(3) == 0);
      end
      i_flt_busy = rnd && ($urandom_range(3) == 0);
      flt_real = (flt_d.size() > 0) && (cyc >= flt_ts[0] + 3);
      if (stray) begin
        i_flt_vld = 1'b1; i_flt_data = rgb_t'($urandom); flt_real = 1'b0;
      end else if (flt_real) begin
        i_flt_vld = 1'b1; i_flt_data = flt_d[0];
      end else begin
        i_flt_vld = 1'b0; i_flt_data = '0;
      end
      #3;
      for (int k = 0; k < 2; k++) begin
        if (i_src_vld[k] && !o_src_busy[k]) begin
          n_cmp++;
          if (!o_gnt[k] || !o_flt_vld || i_flt_busy || o_flt_data !== src_q[k][0]) begin
            n_err++;
            $display("FAIL src_pass req=%0d gnt=%b flt_vld=%b flt_data=%h want_data=%h", k, o_gnt, o_flt_vld, o_flt_data, src_q[k][0]);
          end
          void'(src_q[k].pop_front());
          src_cnt[k]++;
        end
      end
      if (o_flt_vld && !i_flt_busy) begin flt_d.push_back(o_flt_data); flt_ts.push_back(cyc); end
      if (flt_real && !o_flt_busy) begin void'(flt_d.pop_front()); void'(flt_ts.pop_front()); end
      for (int k = 0; k < 2; k++) begin
        if (o_dst_vld[k] && !i_dst_busy[k]) begin
          n_cmp++;
          if (exp_q[k].size() == 0) begin
            n_err++;
            $display("FAIL dst_extra req=%0d got=%h want=none", k, o_dst_data);
          end else begin
            if (o_dst_data !== exp_q[k][0]) begin
              n_err++;
              $display("FAIL dst_data req=%0d got=%h want=%h", k, o_dst_data, exp_q[k][0]);
            end
            void'(exp_q[k].pop_front());
          end
          dst_cnt[k]++;
        end
        if (o_done[k]) begin done_cnt[k]++; rr_last = k; end
      end
      if (o_gnt != 2'b00) begin
        n_cmp++;
        if ($countones(o_gnt) != 1 || (o_src_busy | o_gnt) !== 2'b11) begin
          n_err++;
          $display("FAIL exclusive gnt=%b src_busy=%b want=onehot_with_other_busy", o_gnt, o_src_busy);
        end
      end
      if (o_gnt != 2'b00 && prev_gnt == 2'b00) gnt_log.push_back(o_gnt[1] ? 1 : 0);
      prev_gnt = o_gnt;
      if (!i_rst) begin
        rr_last = 1;
        flt_d.delete(); flt_ts.delete();
        for (int k = 0; k < 2; k++) begin src_q[k].delete(); exp_q[k].delete(); end
      end
      cyc++;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  task automatic wait_done(input int k, input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (done_cnt[k] >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic push_frame(input int k, input int n);
    rgb_t px;
    for (int i = 0; i < n; i++) begin
      px = rgb_t'($urandom);
      src_q[k].push_back(px);
      exp_q[k].push_back(px);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    n_cmp++;
    if (o_gnt !== 2'b00 || o_done !== 2'b00 || o_overrun !== 1'b0 || o_src_busy !== 2'b11 ||
        o_dst_vld !== 2'b00 || o_flt_vld !== 1'b0 || o_flt_busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s got gnt=%b done=%b ovr=%b sbusy=%b dvld=%b fvld=%b fbusy=%b want 00 00 0 11 00 0 0",
               tag, o_gnt, o_done, o_overrun, o_src_busy, o_dst_vld, o_flt_vld, o_flt_busy);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    #3;
    check_idle_outputs("reset_state");
    @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    #3;
    check_idle_outputs("post_release_idle");
  endtask

  task automatic test_single();
    bit ok;
    int base;
    rnd = 1'b0;
    base = done_cnt[0];
    push_frame(0, 4);
    @(negedge clk);
    i_len = {LEN_W'(0), LEN_W'(4)};
    i_req = 2'b01;
    #3;
    n_cmp++;
    if (o_gnt !== 2'b00) begin n_err++; $display("FAIL single_gnt_early got=%b want=00", o_gnt); end
    @(posedge clk); #1;
    n_cmp++;
    if (o_gnt !== 2'b01) begin n_err++; $display("FAIL single_gnt got=%b want=01", o_gnt); end
    i_req = 2'b00;
    wait_done(0, base + 1, 100, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL single_done_timeout got=%0d want=%0d", done_cnt[0], base + 1); end
    #3;
    n_cmp++;
    if (o_done !== 2'b00 || o_gnt !== 2'b00) begin
      n_err++; $display("FAIL single_done_pulse got done=%b gnt=%b want 00 00", o_done, o_gnt);
    end
    n_cmp++;
    if (exp_q[0].size() != 0) begin n_err++; $display("FAIL single_outputs got_left=%0d want=0", exp_q[0].size()); end
  endtask

  task automatic test_round_robin();
    bit ok;
    int f, b0, b1, gb;
    rnd = 1'b1;
    f  = (rr_last == 1) ? 0 : 1;
    b0 = done_cnt[f];
    b1 = done_cnt[1-f];
    gb = gnt_log.size();
    push_frame(f, 4);
    push_frame(1 - f, 2);
    @(negedge clk);
    i_len = {LEN_W'(2), LEN_W'(2)};
    i_req = 2'b11;
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (gnt_log.size() >= gb + 3) begin ok = 1'b1; break; end
    end
    i_req = 2'b00;
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL rr_grant_timeout got=%0d want=3", gnt_log.size() - gb); end
    wait_done(f, b0 + 2, 400, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL rr_done_timeout got=%0d want=%0d", done_cnt[f], b0 + 2); end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (gnt_log.size() != gb + 3 || gnt_log[gb] != f || gnt_log[gb+1] != 1 - f || gnt_log[gb+2] != f) begin
      n_err++;
      $display("FAIL rr_order got_n=%0d first=%0d want_n=3 seq=%0d,%0d,%0d", gnt_log.size() - gb,
               (gnt_log.size() > gb) ? gnt_log[gb] : -1, f, 1 - f, f);
    end
    n_cmp++;
    if (done_cnt[f] != b0 + 2 || done_cnt[1-f] != b1 + 1) begin
      n_err++;
      $display("FAIL rr_done_count got=%0d,%0d want=%0d,%0d", done_cnt[f] - b0, done_cnt[1-f] - b1, 2, 1);
    end
    n_cmp++;
    if (exp_q[0].size() != 0 || exp_q[1].size() != 0) begin
      n_err++; $display("FAIL rr_outputs got_left=%0d,%0d want=0,0", exp_q[0].size(), exp_q[1].size());
    end
    rnd = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok;
    int base, dbase, held;
    rnd = 1'b0;
    base  = done_cnt[0];
    dbase = dst_cnt[0];
    push_frame(0, 8);
    @(negedge clk);
    i_len = {LEN_W'(0), LEN_W'(8)};
    i_req = 2'b01;
    @(posedge clk); #1;
    i_req = 2'b00;
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (dst_cnt[0] >= dbase + 2) begin ok = 1'b1; break; end
    end
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL bp_start_timeout got=%0d want=2", dst_cnt[0] - dbase); end
    held = dst_cnt[0];
    for (int i = 0; i < 6; i++) begin
      dst_force[0] = (i < 5);
      #3;
      n_cmp++;
      if (o_flt_busy !== (i < 5)) begin
        n_err++; $display("FAIL bp_flt_busy cycle=%0d got=%b want=%b", i, o_flt_busy, (i < 5));
      end
      if (i < 5) @(negedge clk);
    end
    n_cmp++;
    if (dst_cnt[0] != held) begin n_err++; $display("FAIL bp_stalled got=%0d want=%0d", dst_cnt[0], held); end
    wait_done(0, base + 1, 200, ok);
    n_cmp++;
    if (!ok || dst_cnt[0] != dbase + 8 || exp_q[0].size() != 0) begin
      n_err++; $display("FAIL bp_delivery got=%0d left=%0d want=8 left=0", dst_cnt[0] - dbase, exp_q[0].size());
    end
  endtask

  task automatic test_zero_len();
    int base;
    base = done_cnt[1];
    @(negedge clk);
    i_len = {LEN_W'(0), LEN_W'(5)};
    i_req = 2'b10;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      if (c == 1) i_req = 2'b00;
      n_cmp++;
      if (o_gnt !== 2'b00 || o_flt_vld !== 1'b0 || o_done !== ((c == 2) ? 2'b10 : 2'b00)) begin
        n_err++;
        $display("FAIL zero_len cycle=%0d got gnt=%b fvld=%b done=%b want 00 0 %b", c, o_gnt, o_flt_vld, o_done,
                 (c == 2) ? 2'b10 : 2'b00);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (done_cnt[1] != base + 1) begin n_err++; $display("FAIL zero_len_count got=%0d want=1", done_cnt[1] - base); end
  endtask

  task automatic test_stray();
    @(negedge clk);
    n_cmp++;
    if (o_overrun !== 1'b0) begin n_err++; $display("FAIL overrun_clean got=%b want=0", o_overrun); end
    stray = 1'b1;
    #3;
    n_cmp++;
    if (o_flt_busy !== 1'b0 || o_dst_vld !== 2'b00) begin
      n_err++; $display("FAIL stray_route got fbusy=%b dvld=%b want 0 00", o_flt_busy, o_dst_vld);
    end
    @(negedge clk);
    stray = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (o_overrun !== 1'b1) begin n_err++; $display("FAIL overrun_sticky got=%b want=1", o_overrun); end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    int sbase, dbase, gb;
    rnd   = 1'b0;
    sbase = src_cnt[0];
    push_frame(0, 4);
    @(negedge clk);
    i_len = {LEN_W'(0), LEN_W'(4)};
    i_req = 2'b01;
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (src_cnt[0] >= sbase + 2) begin ok = 1'b1; break; end
    end
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL midreset_start got=%0d want=2", src_cnt[0] - sbase); end
    dbase = done_cnt[0];
    i_rst = 1'b0;
    i_req = 2'b00;
    #3;
    check_idle_outputs("midreset_state");
    repeat (2) @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    gb = gnt_log.size();
    push_frame(0, 4);
    i_req = 2'b01;
    @(posedge clk); #1;
    n_cmp++;
    if (o_gnt !== 2'b01) begin n_err++; $display("FAIL midreset_regrant got=%b want=01", o_gnt); end
    i_req = 2'b00;
    wait_done(0, dbase + 1, 100, ok);
    repeat (4) @(negedge clk);
    n_cmp++;
    if (!ok || done_cnt[0] != dbase + 1 || exp_q[0].size() != 0 || gnt_log.size() != gb + 1) begin
      n_err++;
      $display("FAIL midreset_frame got done=%0d left=%0d grants=%0d want 1 0 1", done_cnt[0] - dbase,
               exp_q[0].size(), gnt_log.size() - gb);
    end
  endtask

  initial begin : main
    n_cmp = 0; n_err = 0;
    rnd = 1'b0; stray = 1'b0; dst_force = 2'b00;
    i_rst = 1'b0; i_req = 2'b00; i_len = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_zero_len();
    test_stray();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
